// File: rtl/hsadc_capture_controller.sv
`default_nettype none
// ============================================================================
// hsadc_capture_controller: framed dual-channel ADC capture into AXI-Stream.
// Revision: 1.0
// ============================================================================
module hsadc_capture_controller #(
  parameter int unsigned DATA_DELAY    = 2,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] cfg_divider,
  input  logic [15:0] cfg_frame_len,
  input  logic        cfg_dfs,
  input  logic [7:0]  adc_channel_a,
  input  logic [7:0]  adc_channel_b,
  output logic        adc_enc,
  output logic        adc_s1,
  output logic        adc_s2,
  output logic        adc_dfs,
  output logic [15:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        busy,
  output logic        done,
  output logic [15:0] overrun_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  localparam logic [15:0] DELAY_PHASE = 16'(DATA_DELAY);
  localparam logic [15:0] MIN_PERIOD  = 16'(DATA_DELAY + 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] settle_cnt_q, settle_cnt_d;
  logic [15:0] phase_q, phase_d;
  logic [15:0] period_q, period_d;
  logic [15:0] frame_len_q, frame_len_d;
  logic [15:0] sample_idx_q, sample_idx_d;
  logic [15:0] overrun_q, overrun_d;
  logic [15:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        enc_q, enc_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        dfs_q, dfs_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic handshake;
  logic final_sample;
  logic out_free;

  assign handshake    = tvalid_q && m_tready;
  assign out_free     = !tvalid_q || handshake;
  // Length 0 means continuous capture, so it never matches a final index.
  assign final_sample = (frame_len_q != 16'd0) && (sample_idx_q == frame_len_q - 16'd1);

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    phase_d      = phase_q;
    period_d     = period_q;
    frame_len_d  = frame_len_q;
    sample_idx_d = sample_idx_q;
    overrun_d    = overrun_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q && !handshake;
    tlast_d      = tlast_q;
    enc_d        = 1'b0;
    s1_d         = 1'b1;
    s2_d         = 1'b0;
    dfs_d        = dfs_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          period_d     = (cfg_divider < MIN_PERIOD) ? MIN_PERIOD : cfg_divider;
          frame_len_d  = cfg_frame_len;
          dfs_d        = cfg_dfs;
          overrun_d    = 16'd0;
          settle_cnt_d = 16'd0;
          state_d      = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (stop) begin
          state_d = ST_DRAIN;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d      = ST_RUN;
          phase_d      = 16'd0;
          sample_idx_d = 16'd0;
          enc_d        = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q + 16'd1;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d = ST_DRAIN;
        end else begin
          phase_d = (phase_q >= period_q - 16'd1) ? 16'd0 : phase_q + 16'd1;
          enc_d   = (phase_d == 16'd0);
          // Sampling instant is fixed by the phase counter; backpressure only drops.
          if (phase_q == DELAY_PHASE) begin
            if (out_free) begin
              tdata_d  = {adc_channel_a, adc_channel_b};
              tvalid_d = 1'b1;
              tlast_d  = final_sample;
            end else if (overrun_q != 16'hFFFF) begin
              overrun_d = overrun_q + 16'd1;
            end
            sample_idx_d = sample_idx_q + 16'd1;
            if (final_sample) begin
              state_d = ST_DRAIN;
              enc_d   = 1'b0;
            end
          end
        end
      end

      ST_DRAIN: begin
        if (out_free) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= 16'd0;
      phase_q      <= 16'd0;
      period_q     <= 16'd0;
      frame_len_q  <= 16'd0;
      sample_idx_q <= 16'd0;
      overrun_q    <= 16'd0;
      tdata_q      <= 16'd0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      enc_q        <= 1'b0;
      s1_q         <= 1'b1;
      s2_q         <= 1'b0;
      dfs_q        <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      phase_q      <= phase_d;
      period_q     <= period_d;
      frame_len_q  <= frame_len_d;
      sample_idx_q <= sample_idx_d;
      overrun_q    <= overrun_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      enc_q        <= enc_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      dfs_q        <= dfs_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign adc_enc       = enc_q;
  assign adc_s1        = s1_q;
  assign adc_s2        = s2_q;
  assign adc_dfs       = dfs_q;
  assign m_tdata       = tdata_q;
  assign m_tvalid      = tvalid_q;
  assign m_tlast       = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overrun_count = overrun_q;

endmodule
`default_nettype wire
